// File: rtl/loc_sram_row_reader.sv
// loc_sram_row_reader
//   Read-side controller for the location SRAM. A command names a base row and
//   a row count. Each row is read over the SRAM read port, then streamed out as
//   BW-bit elements with valid/ready handshaking. Element 0 is the MSB slice of
//   the row. When CLEAR_AFTER_READ is set, each fully consumed row is written
//   back to zero through the SRAM write port.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   cmd_valid/ready     command handshake; ready only while idle
//   cmd_base, cmd_rows  first row and number of rows (0..2^ADDR_SPACE)
//   busy, done          not idle; one-cycle completion pulse
//   sram_raddr/rdata    SRAM read port, 1-cycle read latency
//   sram_wsb/waddr/...  SRAM write port (active-low enable, zero data, no mask)
//   out_*               element stream: data, index in row, row, last flag
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for a command, cmd_ready high
// RD_ISSUE | read address presented, SRAM samples it at the end of the cycle
// RD_WAIT  | read data valid, captured into row_buf
// STREAM   | presenting row_buf elements to the sink
// CLEAR    | writing zero to the row that was just consumed

module loc_sram_row_reader #(
  parameter int ADDR_SPACE       = 8,
  parameter int BW               = 5,
  parameter int D                = 256,
  parameter int CLEAR_AFTER_READ = 1,
  localparam int VW              = $clog2(D)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_SPACE-1:0] cmd_base,
  input  logic [ADDR_SPACE:0]   cmd_rows,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_SPACE-1:0] sram_raddr,
  input  logic [D*BW-1:0]       sram_rdata,
  output logic                  sram_wsb,
  output logic [ADDR_SPACE-1:0] sram_waddr,
  output logic [D*BW-1:0]       sram_wdata,
  output logic [D-1:0]          sram_bytemask,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BW-1:0]         out_data,
  output logic [VW-1:0]         out_vid,
  output logic [ADDR_SPACE-1:0] out_row,
  output logic                  out_last
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] RD_ISSUE = 3'd1;
  localparam logic [2:0] RD_WAIT  = 3'd2;
  localparam logic [2:0] STREAM   = 3'd3;
  localparam logic [2:0] CLEAR    = 3'd4;

  localparam logic [VW-1:0]         VID_LAST = VW'(D - 1);
  localparam logic [VW-1:0]         VID_ONE  = VW'(1);
  localparam logic [ADDR_SPACE:0]   REM_ONE  = (ADDR_SPACE + 1)'(1);
  localparam logic [ADDR_SPACE-1:0] ROW_ONE  = ADDR_SPACE'(1);

  logic [2:0]            state;
  logic [ADDR_SPACE-1:0] row;
  logic [ADDR_SPACE-1:0] raddr_q;
  logic [ADDR_SPACE:0]   remaining;
  logic [D*BW-1:0]       row_buf;
  logic [VW-1:0]         vid;
  logic                  done_q;

  logic accept;
  logic row_end;

  assign accept  = (state == STREAM) && out_ready;
  assign row_end = accept && (vid == VID_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      row       <= '0;
      raddr_q   <= '0;
      remaining <= '0;
      row_buf   <= '0;
      vid       <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            row       <= cmd_base;
            remaining <= cmd_rows;
            if (cmd_rows == '0) begin
              done_q <= 1'b1;
            end else begin
              // Address is registered one cycle ahead so it is stable for
              // the whole RD_ISSUE cycle.
              raddr_q <= cmd_base;
              state   <= RD_ISSUE;
            end
          end
        end
        RD_ISSUE: state <= RD_WAIT;
        RD_WAIT: begin
          row_buf <= sram_rdata;
          vid     <= '0;
          state   <= STREAM;
        end
        STREAM: begin
          if (accept) begin
            row_buf <= {row_buf[D*BW-BW-1:0], {BW{1'b0}}};
            vid     <= vid + VID_ONE;
            if (row_end) begin
              remaining <= remaining - REM_ONE;
              if (CLEAR_AFTER_READ != 0) begin
                // row advances after the clear so the write hits this row
                state <= CLEAR;
              end else begin
                row <= row + ROW_ONE;
                if (remaining > REM_ONE) begin
                  raddr_q <= row + ROW_ONE;
                  state   <= RD_ISSUE;
                end else begin
                  done_q <= 1'b1;
                  state  <= IDLE;
                end
              end
            end
          end
        end
        CLEAR: begin
          row <= row + ROW_ONE;
          if (remaining != '0) begin
            raddr_q <= row + ROW_ONE;
            state   <= RD_ISSUE;
          end else begin
            done_q <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cmd_ready     = (state == IDLE);
  assign busy          = (state != IDLE);
  assign done          = done_q;
  assign sram_raddr    = raddr_q;
  assign sram_wsb      = (state != CLEAR);
  assign sram_waddr    = row;
  assign sram_wdata    = '0;
  assign sram_bytemask = '0;
  assign out_valid     = (state == STREAM);
  assign out_data      = row_buf[D*BW-1 -: BW];
  assign out_vid       = vid;
  assign out_row       = row;
  // remaining still counts the current row while it streams
  assign out_last      = (state == STREAM) && (vid == VID_LAST) && (remaining == REM_ONE);

endmodule
